regfile_wb_arbiter: RTL and testbench

- Write-back controller that sequences the single register-file write port (regwr/rd/rddata) of the RISC-V core.
- Two producers, the ALU result path and the load/memory result path, compete through valid/ready handshakes. A round-robin arbiter resolves the contention and drives a registered write command.
- Keeps a pending-write scoreboard (one bit per architectural register) that issue logic reads to detect RAW hazards.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 35 +++
 rtl/regfile_wb_arbiter.sv | 107 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: default widths, write-back requester indices, command struct.
package riscv_pkg;

    localparam int unsigned ADDRSIZE_DEFAULT = 5;
    localparam int unsigned WORDSIZE_DEFAULT = 64;

    // Requester indices into the write-back arbiter request/grant vectors
    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_MEM = 1;

    // Write-back command as selected by the arbiter
    typedef struct packed {
        logic                        valid;
        logic [ADDRSIZE_DEFAULT-1:0] rd;
        logic [WORDSIZE_DEFAULT-1:0] data;
    } wb_cmd_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Requester 0 wins the first conflict after reset;
// the pointer only moves when both requesters are active.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Index of the requester granted at the most recent conflict
    logic ptr_q;

    // Grant decode; nothing is granted while reset is asserted
    always_comb begin
        gnt = 2'b00;
        if (rst) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Pointer follows the conflict winner; uncontested grants leave it alone
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b1;
        end else if (req == 2'b11) begin
            ptr_q <= gnt[1];
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back controller: arbitrates ALU and load results onto the
// single write port and tracks outstanding writes per register for hazard checks.
module regfile_wb_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned  ADDRSIZE = ADDRSIZE_DEFAULT,
    parameter int unsigned  WORDSIZE = WORDSIZE_DEFAULT,
    localparam int unsigned RFSIZE   = 1 << ADDRSIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDRSIZE-1:0] alu_rd,
    input  logic [WORDSIZE-1:0] alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDRSIZE-1:0] mem_rd,
    input  logic [WORDSIZE-1:0] mem_data,
    input  logic                issue_valid,
    input  logic [ADDRSIZE-1:0] issue_rd,
    output logic                regwr,
    output logic [ADDRSIZE-1:0] rd,
    output logic [WORDSIZE-1:0] rddata,
    output logic [RFSIZE-1:0]   pending
);

    logic [1:0]          req;
    logic [1:0]          gnt;
    // Command struct field widths follow the package defaults
    wb_cmd_t             win;
    logic                regwr_q;
    logic [ADDRSIZE-1:0] rd_q;
    logic [WORDSIZE-1:0] rddata_q;
    logic [RFSIZE-1:0]   pending_d;
    logic [RFSIZE-1:0]   pending_q;

    assign req[REQ_ALU] = alu_valid;
    assign req[REQ_MEM] = mem_valid;

    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign alu_ready = gnt[REQ_ALU];
    assign mem_ready = gnt[REQ_MEM];

    // Select the accepted producer's command
    always_comb begin
        win = '0;
        if (gnt[REQ_ALU]) begin
            win.valid = 1'b1;
            win.rd    = alu_rd;
            win.data  = alu_data;
        end else if (gnt[REQ_MEM]) begin
            win.valid = 1'b1;
            win.rd    = mem_rd;
            win.data  = mem_data;
        end
    end

    // Registered write command; x0 writes load address/data but never enable the port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwr_q  <= 1'b0;
            rd_q     <= '0;
            rddata_q <= '0;
        end else begin
            regwr_q <= win.valid && (win.rd != '0);
            if (win.valid) begin
                rd_q     <= win.rd;
                rddata_q <= win.data;
            end
        end
    end

    // Scoreboard next state: retire the write on the port, then mark the issuing
    // destination so a newer producer wins over a same-edge retirement
    always_comb begin
        pending_d = pending_q;
        if (regwr_q) begin
            pending_d[rd_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Scoreboard state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign regwr   = regwr_q;
    assign rd      = rd_q;
    assign rddata  = rddata_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios then randomized traffic,
// checked against a transaction-level model of arbitration, write-back and hazard tracking.
module tb_regfile_wb_arbiter;

    localparam int ALU = 0;
    localparam int MEM = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0, issue_valid = 1'b0;
    logic        alu_ready, mem_ready, regwr;
    logic [4:0]  alu_rd = '0, mem_rd = '0, issue_rd = '0, rd;
    logic [63:0] alu_data = '0, mem_data = '0, rddata;
    logic [31:0] pending;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .regwr       (regwr),
        .rd          (rd),
        .rddata      (rddata),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    typedef struct { int due; logic [4:0] rd; logic [63:0] data; } wexp_t;
    typedef struct { int due; logic [31:0] pend; } pexp_t;
    wexp_t wq[$];
    pexp_t pq[$];
    bit    mon_en = 0;

    // Stimulus-side producer intent
    logic        a_v = 0, m_v = 0, iv = 0;
    logic [4:0]  a_rd = 0, m_rd = 0, ird = 0;
    logic [63:0] a_d = 0, m_d = 0;
    bit          got_a, got_m;

    // Reference model state
    int          last_conflict = MEM;   // so ALU takes the first conflict
    bit [31:0]   mdl_pend = '0;
    bit          wr_now = 0;            // model: a write is on the port this cycle
    logic [4:0]  wr_now_rd = 0;

    // One clock cycle: apply intent, check handshake, predict outcome, advance
    task automatic step();
        wexp_t   w;
        pexp_t   p;
        bit      xfer;
        logic [4:0]  xrd;
        logic [63:0] xd;
        bit [31:0]   nxt;
        alu_valid = a_v; alu_rd = a_rd; alu_data = a_d;
        mem_valid = m_v; mem_rd = m_rd; mem_data = m_d;
        issue_valid = iv; issue_rd = ird;
        #1;
        got_a = a_v && (!m_v || last_conflict == MEM);
        got_m = m_v && (!a_v || last_conflict == ALU);
        chk("alu_ready", alu_ready, got_a);
        chk("mem_ready", mem_ready, got_m);
        if (a_v && m_v) last_conflict = got_a ? ALU : MEM;
        xfer = got_a || got_m;
        xrd  = got_a ? a_rd : m_rd;
        xd   = got_a ? a_d : m_d;
        if (xfer && xrd != 0) begin
            w.due = cyc + 1; w.rd = xrd; w.data = xd;
            wq.push_back(w);
        end
        nxt = mdl_pend;
        if (wr_now) nxt[wr_now_rd] = 1'b0;
        if (iv && ird != 0) nxt[ird] = 1'b1;
        mdl_pend = nxt;
        p.due = cyc + 1; p.pend = nxt;
        pq.push_back(p);
        wr_now = xfer && xrd != 0;
        wr_now_rd = xrd;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        wq.delete(); pq.delete();
        last_conflict = MEM; mdl_pend = '0; wr_now = 0;
    endtask

    // Monitor: registered outputs are compared mid-cycle against the queued predictions
    always @(negedge clk) begin
        if (mon_en) begin
            if (regwr) begin
                if (wq.size() == 0) begin
                    chk("regwr_unexpected", regwr, 1'b0);
                end else begin
                    wexp_t e;
                    e = wq.pop_front();
                    chk("wr_latency", cyc, e.due);
                    chk("wr_rd", rd, e.rd);
                    chk("wr_data", rddata, e.data);
                end
            end else if (wq.size() > 0 && wq[0].due <= cyc) begin
                chk("regwr_missing", regwr, 1'b1);
                void'(wq.pop_front());
            end
            if (pq.size() > 0 && pq[0].due == cyc) begin
                pexp_t e;
                e = pq.pop_front();
                chk("pending", pending, e.pend);
            end
        end
    end

    initial begin
        // Power-on reset
        #12;
        chk("rst_regwr", regwr, 1'b0);
        chk("rst_rd", rd, 5'd0);
        chk("rst_rddata", rddata, 64'd0);
        chk("rst_pending", pending, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; mon_en = 1;

        // Traffic, then reset mid-stream with ALU valid
        a_v = 1; a_rd = 9; a_d = 64'h99; iv = 1; ird = 4;
        step();
        step();
        a_v = 1; a_rd = 10; a_d = 64'hA0; iv = 0;
        alu_valid = 1; alu_rd = a_rd; alu_data = a_d; issue_valid = 0;
        #2;
        mon_en = 0;
        rst = 1'b0;
        #1;
        chk("midrst_regwr", regwr, 1'b0);
        chk("midrst_pending", pending, 32'd0);
        chk("midrst_alu_ready", alu_ready, 1'b0);
        chk("midrst_mem_ready", mem_ready, 1'b0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1; mon_en = 1;

        // First accepted result after reset: written exactly one cycle later
        a_v = 1; a_rd = 5; a_d = 64'h11;
        step();
        a_v = 0;
        step();

        // Contention: ALU, MEM, ALU, MEM
        a_v = 1; a_rd = 1; a_d = 64'h1111; m_v = 1; m_rd = 2; m_d = 64'h2222;
        repeat (4) step();
        a_v = 0; m_v = 0;
        step();

        // Single requester does not move the pointer; next conflict goes to ALU
        m_v = 1; m_rd = 6; m_d = 64'h66;
        repeat (3) step();
        a_v = 1; a_rd = 8; a_d = 64'h88;
        step();
        chk("post_single_conflict_alu", got_a, 1'b1);
        a_v = 0;
        step();   // mem still waiting, now accepted
        m_v = 0;
        step();

        // x0: accepted, no write enable, scoreboard untouched
        a_v = 1; a_rd = 0; a_d = 64'hDEAD;
        step();
        a_v = 0;
        step();

        // Scoreboard set / clear / same-edge set-wins
        iv = 1; ird = 7;
        step();
        iv = 0; a_v = 1; a_rd = 7; a_d = 64'h77;
        step();
        a_v = 0;
        step();   // regwr high for r7 this cycle, clears at next edge
        step();
        iv = 1; ird = 7;
        step();
        iv = 0; a_v = 1; a_rd = 7; a_d = 64'h78;
        step();
        a_v = 0; iv = 1; ird = 7;   // issue coincides with the clearing edge
        step();
        iv = 0;
        step();
        chk("set_wins_pending7", pending[7], 1'b1);

        // Stall hold: MEM wins one conflict, then loses with rd=3/0xAB held
        a_v = 1; a_rd = 11; a_d = 64'hB1; m_v = 1; m_rd = 4; m_d = 64'h44;
        step();
        if (got_m) begin a_v = 1; m_rd = 3; m_d = 64'hAB; end
        step();
        chk("stall_mem_lost", got_m, 1'b0);
        a_v = 0;
        step();
        chk("stall_mem_accepted", got_m, 1'b1);
        m_v = 0;
        step();

        // Randomized traffic; producers hold until accepted
        for (int i = 0; i < 400; i++) begin
            if (!a_v || got_a) begin
                a_v = ($urandom_range(0, 2) != 0);
                a_rd = 5'($urandom); a_d = {$urandom, $urandom};
            end
            if (!m_v || got_m) begin
                m_v = ($urandom_range(0, 2) != 0);
                m_rd = 5'($urandom); m_d = {$urandom, $urandom};
            end
            iv = ($urandom_range(0, 2) == 0);
            ird = 5'($urandom);
            got_a = 0; got_m = 0;
            step();
        end
        a_v = 0; m_v = 0; iv = 0;
        step();
        step();
        chk("drain_queue_empty", 32'(wq.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
